wb_slot_scheduler: RTL and testbench

Arbitrates a single register-file writeback port among NREQ fixed-latency execution units, such as the ALU, the multiplier delay pipe and the load path.
- Each unit asks to issue an op with a known result latency.
- The scheduler grants the issue only if the writeback slot that many cycles ahead is free, then reserves it.
- When the slot arrives, the scheduler drives the tag and source of the result.
- It sits between decode/issue and the execution-unit delay lines and guarantees no writeback-port collisions.

---
 rtl/wb_slot_scheduler.sv | 141 ++++++++++++++
 tb/tb_wb_slot_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : wb_slot_scheduler
// Purpose  : Reserves future cycles of a single register-file writeback port
//            for fixed-latency execution units. An issue is granted only
//            when the writeback slot L cycles ahead is free. When that slot
//            arrives, the result's tag and source unit are driven on wb_*.
//            Optional macro WB_SCHED_OCC_EN adds the occ/full occupancy outputs.
// Revision : 1.0 - initial release
// ============================================================================
module wb_slot_scheduler #(
  parameter int NREQ      = 2,
  parameter int MAX_LAT   = 8,
  parameter int LAT_WIDTH = 4,
  parameter int TAG_WIDTH = 5,
  parameter int SRC_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*LAT_WIDTH-1:0] req_lat,
  input  logic [NREQ*TAG_WIDTH-1:0] req_tag,
  input  logic                      flush,
  output logic [NREQ-1:0]           grant,
  output logic                      lat_err,
  output logic                      wb_valid,
  output logic [TAG_WIDTH-1:0]      wb_tag,
  output logic [SRC_WIDTH-1:0]      wb_src
`ifdef WB_SCHED_OCC_EN
  ,
  output logic [$clog2(MAX_LAT+1)-1:0] occ,
  output logic                         full
`endif
);

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [SRC_WIDTH-1:0] src;
  } slot_t;

  // ent[k] holds the writeback that becomes visible on wb_* k cycles from now
  slot_t                ent     [1:MAX_LAT];
  slot_t                ent_nxt [1:MAX_LAT];
  // ins[L] is the entry granted this cycle with latency L
  slot_t                ins     [1:MAX_LAT];
  slot_t                wb_nxt;
  logic [SRC_WIDTH-1:0] rr_ptr;
  logic [SRC_WIDTH-1:0] rr_nxt;
  logic                 lat_bad;

  // Rotated-priority grant: each latency slot goes to the first eligible unit
  always_comb begin
    int                   idx;
    int                   last_idx;
    logic                 any_grant;
    logic [LAT_WIDTH-1:0] lat_j;
    grant     = '0;
    lat_bad   = 1'b0;
    any_grant = 1'b0;
    last_idx  = 0;
    idx       = 0;
    lat_j     = '0;
    for (int k = 1; k <= MAX_LAT; k++) ins[k] = '0;
    for (int j = 0; j < NREQ; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      lat_j = req_lat[idx*LAT_WIDTH +: LAT_WIDTH];
      if (req_valid[idx] && ((lat_j == '0) || (int'(lat_j) > MAX_LAT)))
        lat_bad = 1'b1;
      for (int k = 1; k <= MAX_LAT; k++) begin
        // ins[k] already set means an earlier unit in the scan took slot k
        if (req_valid[idx] && !flush && !rst && (int'(lat_j) == k) &&
            !ent[k].valid && !ins[k].valid) begin
          grant[idx]    = 1'b1;
          ins[k].valid  = 1'b1;
          ins[k].tag    = req_tag[idx*TAG_WIDTH +: TAG_WIDTH];
          ins[k].src    = SRC_WIDTH'(idx);
          any_grant     = 1'b1;
          last_idx      = idx;
        end
      end
    end
    rr_nxt = any_grant ? SRC_WIDTH'((last_idx + 1) % NREQ) : rr_ptr;
  end

  // Shift the reservation line one slot closer, merging this cycle's grants
  always_comb begin
    wb_nxt = ins[1].valid ? ins[1] : ent[1];
    for (int k = 1; k < MAX_LAT; k++)
      ent_nxt[k] = ins[k+1].valid ? ins[k+1] : ent[k+1];
    ent_nxt[MAX_LAT] = '0;
    if (flush) begin
      wb_nxt.valid = 1'b0;
      for (int k = 1; k <= MAX_LAT; k++) ent_nxt[k] = '0;
    end
  end

  // Reservation line, writeback outputs, round-robin pointer and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= MAX_LAT; k++) ent[k] <= '0;
      rr_ptr   <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_src   <= '0;
      lat_err  <= 1'b0;
    end else begin
      for (int k = 1; k <= MAX_LAT; k++) ent[k] <= ent_nxt[k];
      rr_ptr   <= rr_nxt;
      lat_err  <= lat_bad;
      wb_valid <= wb_nxt.valid;
      // tag/src only move on a real writeback so idle cycles hold them
      if (wb_nxt.valid) begin
        wb_tag <= wb_nxt.tag;
        wb_src <= wb_nxt.src;
      end
    end
  end

`ifdef WB_SCHED_OCC_EN
  logic [$clog2(MAX_LAT+1)-1:0] occ_nxt;

  // Count of live reservations after this edge's update
  always_comb begin
    occ_nxt = '0;
    for (int k = 1; k <= MAX_LAT; k++)
      occ_nxt = occ_nxt + {{($clog2(MAX_LAT+1)-1){1'b0}}, ent_nxt[k].valid};
  end

  // Occupancy register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ <= '0;
    else     occ <= occ_nxt;
  end

  assign full = (int'(occ) == MAX_LAT - 1);
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_slot_scheduler
// Purpose  : Scoreboard bench for wb_slot_scheduler. The stimulus side keeps a
//            calendar of booked writeback cycles and checks grants. A monitor
//            compares wb_* and lat_err against that calendar every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_slot_scheduler;
  localparam int NREQ = 2;
  localparam int ML   = 8;
  localparam int LW   = 4;
  localparam int TW   = 5;
  localparam int SW   = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*LW-1:0] req_lat = '0;
  logic [NREQ*TW-1:0] req_tag = '0;
  logic               flush = 1'b0;
  logic [NREQ-1:0]    grant;
  logic               lat_err;
  logic               wb_valid;
  logic [TW-1:0]      wb_tag;
  logic [SW-1:0]      wb_src;
`ifdef WB_SCHED_OCC_EN
  logic [$clog2(ML+1)-1:0] occ;
  logic                    full;
`endif

  wb_slot_scheduler #(.NREQ(NREQ), .MAX_LAT(ML), .LAT_WIDTH(LW),
                      .TAG_WIDTH(TW), .SRC_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lat(req_lat),
    .req_tag(req_tag), .flush(flush), .grant(grant), .lat_err(lat_err),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_src(wb_src)
`ifdef WB_SCHED_OCC_EN
    , .occ(occ), .full(full)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: calendar of booked writeback cycles
  int  checks   = 0;
  int  failures = 0;
  int  rr_m     = 0;
  bit  in_reset = 1'b1;
  bit            exp_wb  [int];
  logic [TW-1:0] exp_tag [int];
  logic [SW-1:0] exp_src [int];
  bit            exp_le  [int];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare registered outputs with the calendar each cycle
  always @(negedge clk) begin
    if (!in_reset) begin
      chk("wb_valid", int'(wb_valid), int'(exp_wb.exists(cyc)));
      if (wb_valid && exp_wb.exists(cyc)) begin
        chk("wb_tag", int'(wb_tag), int'(exp_tag[cyc]));
        chk("wb_src", int'(wb_src), int'(exp_src[cyc]));
      end
      chk("lat_err", int'(lat_err), int'(exp_le.exists(cyc)));
      if (exp_wb.exists(cyc)) begin
        exp_wb.delete(cyc); exp_tag.delete(cyc); exp_src.delete(cyc);
      end
      if (exp_le.exists(cyc)) exp_le.delete(cyc);
    end
  end

  // One cycle of stimulus; predicts grants and books expected writebacks
  task automatic step(input logic [1:0] v, input int l0, input int l1,
                      input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                      input logic fl);
    int lat [NREQ];
    logic [TW-1:0] tg [NREQ];
    logic [NREQ-1:0] g_exp;
    int  last;
    bit  any;
    bit  bad;
    @(negedge clk);
    req_valid = v;
    req_lat   = {LW'(l1), LW'(l0)};
    req_tag   = {t1, t0};
    flush     = fl;
    #1;
    lat[0] = l0; lat[1] = l1; tg[0] = t0; tg[1] = t1;
    g_exp = '0; any = 0; bad = 0; last = 0;
    for (int j = 0; j < NREQ; j++) begin
      int i;
      i = (rr_m + j) % NREQ;
      if (v[i] && (lat[i] < 1 || lat[i] > ML)) bad = 1;
      if (!fl && v[i] && lat[i] >= 1 && lat[i] <= ML &&
          !exp_wb.exists(cyc + lat[i])) begin
        g_exp[i] = 1'b1;
        exp_wb[cyc + lat[i]]  = 1'b1;
        exp_tag[cyc + lat[i]] = tg[i];
        exp_src[cyc + lat[i]] = SW'(i);
        any  = 1;
        last = i;
      end
    end
    if (any) rr_m = (last + 1) % NREQ;
    if (fl) begin
      for (int k = cyc + 1; k <= cyc + ML; k++)
        if (exp_wb.exists(k)) begin
          exp_wb.delete(k); exp_tag.delete(k); exp_src.delete(k);
        end
    end
    if (bad) exp_le[cyc + 1] = 1'b1;
    chk("grant", int'(grant), int'(g_exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 0, 0, '0, '0, 1'b0);
  endtask

  function automatic int rnd_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15));
    return int'($urandom_range(1, ML));
  endfunction

  task automatic rst_outputs_zero();
    chk("rst_grant", int'(grant), 0);
    chk("rst_wb_valid", int'(wb_valid), 0);
    chk("rst_lat_err", int'(lat_err), 0);
  endtask

  // Asynchronous reset asserted mid-cycle while random requests are present
  task automatic do_reset(input int ncyc);
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_reset = 1'b1;
    req_valid = NREQ'($urandom);
    req_lat = {LW'(rnd_lat()), LW'(rnd_lat())};
    req_tag = (NREQ*TW)'($urandom);
    exp_wb.delete(); exp_tag.delete(); exp_src.delete(); exp_le.delete();
    rr_m = 0;
    #1 rst_outputs_zero();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      req_valid = NREQ'($urandom);
      req_lat = {LW'(rnd_lat()), LW'(rnd_lat())};
      #1 rst_outputs_zero();
    end
    @(negedge clk);
    req_valid = '0;
    flush = 1'b0;
    rst = 1'b0;
    in_reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_outputs_zero();
    @(negedge clk);
    rst = 1'b0;
    in_reset = 1'b0;
    idle(2);

    // single issue, then a slot conflict and its retry
    step(2'b01, 3, 0, 5'd5, 5'd0, 1'b0);
    step(2'b10, 0, 2, 5'd0, 5'd9, 1'b0);
    step(2'b10, 0, 2, 5'd0, 5'd9, 1'b0);
    idle(10);

    // round-robin on the same latency, then different latencies
    step(2'b11, 4, 4, 5'd1, 5'd2, 1'b0);
    step(2'b11, 4, 4, 5'd3, 5'd4, 1'b0);
    step(2'b11, 4, 5, 5'd6, 5'd7, 1'b0);
    idle(10);

    // flush kills a pending reservation and blocks same-cycle grants
    step(2'b01, 6, 0, 5'd11, 5'd0, 1'b0);
    idle(1);
    step(2'b01, 2, 0, 5'd12, 5'd0, 1'b1);
    idle(10);

    // illegal latencies: never granted, lat_err the following cycle
    step(2'b01, 0, 0, 5'd13, 5'd0, 1'b0);
    step(2'b01, 9, 0, 5'd14, 5'd0, 1'b0);
    idle(10);

    // edge latencies
    step(2'b11, 1, ML, 5'd15, 5'd16, 1'b0);
    step(2'b11, ML, ML, 5'd17, 5'd18, 1'b0);
    idle(ML + 2);

    // reset in the middle of pending reservations
    step(2'b11, 5, 7, 5'd19, 5'd20, 1'b0);
    do_reset(3);
    idle(ML + 2);

    // randomized traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
      else step(2'($urandom), rnd_lat(), rnd_lat(), TW'($urandom), TW'($urandom),
                ($urandom_range(0, 24) == 0));
    end
    idle(ML + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
